// File: rtl/ibus_bridge16.sv
// ibus_bridge16: 32-bit instruction fetch served as two little-endian 16-bit memory reads, with a hang watchdog.
// Define FETCH_CACHE_EN to add a one-entry fetch cache; without it invalidate_i is ignored.
module ibus_bridge16 #(
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] iadr_i,
    input  logic [1:0]        isiz_i,
    output logic              iack_o,
    output logic [31:0]       idat_o,
    output logic [ADDR_W-1:0] madr_o,
    output logic              mcyc_o,
    output logic              mstb_o,
    input  logic [15:0]       mdat_i,
    input  logic              mack_i,
    input  logic              invalidate_i,
    output logic              timeout_o
);
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_ACK} state_e;

    // The watchdog aborts on the wait cycle that brings the count to TIMEOUT.
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] madr_q;
    logic [15:0]       lo_q;
    logic [31:0]       idat_q;
    logic              mcyc_q;
    logic              mstb_q;
    logic              iack_q;
    logic              timeout_q;
    logic              wdrawn_q;
    logic [7:0]        wdog_q;

    logic              req_d;
    logic              withdraw_d;
    logic              hit_d;
    logic [31:0]       hit_dat_d;
    logic [ADDR_W-1:0] base_d;
    logic [ADDR_W-1:0] madr_hi_d;

    assign req_d      = (isiz_i == 2'b10);
    assign base_d     = {iadr_i[ADDR_W-1:2], 2'b00};
    assign madr_hi_d  = base_q + ADDR_W'(2);
    // Once a request is dropped mid-fetch it stays dropped until the halfword ends.
    assign withdraw_d = wdrawn_q | ~req_d;

`ifdef FETCH_CACHE_EN
    logic              cvld_q;
    logic [ADDR_W-1:0] ctag_q;
    logic [31:0]       cdat_q;
    logic              unused_ok;

    assign hit_d     = cvld_q & ~invalidate_i & (ctag_q == base_d);
    assign hit_dat_d = cdat_q;
    assign unused_ok = ^iadr_i[1:0];
`else
    logic              unused_ok;

    assign hit_d     = 1'b0;
    assign hit_dat_d = 32'h0;
    assign unused_ok = ^{iadr_i[1:0], invalidate_i};
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            madr_q    <= '0;
            lo_q      <= '0;
            idat_q    <= '0;
            mcyc_q    <= 1'b0;
            mstb_q    <= 1'b0;
            iack_q    <= 1'b0;
            timeout_q <= 1'b0;
            wdrawn_q  <= 1'b0;
            wdog_q    <= '0;
`ifdef FETCH_CACHE_EN
            cvld_q    <= 1'b0;
            ctag_q    <= '0;
            cdat_q    <= '0;
`endif
        end else begin
            iack_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef FETCH_CACHE_EN
            if (invalidate_i) begin
                cvld_q <= 1'b0;
            end
`endif
            case (state_q)
                S_IDLE: begin
                    if (req_d) begin
                        base_q   <= base_d;
                        wdrawn_q <= 1'b0;
                        wdog_q   <= '0;
                        if (hit_d) begin
                            state_q <= S_ACK;
                            iack_q  <= 1'b1;
                            idat_q  <= hit_dat_d;
                        end else begin
                            state_q <= S_LO;
                            mcyc_q  <= 1'b1;
                            mstb_q  <= 1'b1;
                            madr_q  <= base_d;
                        end
                    end
                end
                S_LO, S_HI: begin
                    wdrawn_q <= withdraw_d;
                    if (mack_i) begin
                        wdog_q <= '0;
                        if (withdraw_d) begin
                            state_q <= S_IDLE;
                            mcyc_q  <= 1'b0;
                            mstb_q  <= 1'b0;
                        end else if (state_q == S_LO) begin
                            lo_q    <= mdat_i;
                            madr_q  <= madr_hi_d;
                            state_q <= S_HI;
                        end else begin
                            idat_q  <= {mdat_i, lo_q};
                            iack_q  <= 1'b1;
                            mcyc_q  <= 1'b0;
                            mstb_q  <= 1'b0;
                            state_q <= S_ACK;
`ifdef FETCH_CACHE_EN
                            if (!invalidate_i) begin
                                cvld_q <= 1'b1;
                                ctag_q <= base_q;
                                cdat_q <= {mdat_i, lo_q};
                            end
`endif
                        end
                    end else if (wdog_q == WDOG_LAST) begin
                        // All-zero is an illegal opcode, so the CPU traps instead of hanging.
                        wdog_q    <= '0;
                        timeout_q <= 1'b1;
                        mcyc_q    <= 1'b0;
                        mstb_q    <= 1'b0;
`ifdef FETCH_CACHE_EN
                        cvld_q    <= 1'b0;
`endif
                        if (withdraw_d) begin
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_ACK;
                            iack_q  <= 1'b1;
                            idat_q  <= 32'h0;
                        end
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign iack_o    = iack_q;
    assign idat_o    = idat_q;
    assign madr_o    = madr_q;
    assign mcyc_o    = mcyc_q;
    assign mstb_o    = mstb_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_ibus_bridge16.sv
// Bench for ibus_bridge16: a transaction-level model lays out the whole cycle timeline up front,
// one process drives it and one process compares every output on every cycle.
module tb_ibus_bridge16;
    localparam int AW   = 64;
    localparam int TO   = 4;
    localparam int MAXC = 8192;
`ifdef FETCH_CACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    localparam int K_NORM  = 0;
    localparam int K_TO_LO = 1;
    localparam int K_TO_HI = 2;
    localparam int K_WD_LO = 3;
    localparam int K_WD_HI = 4;
    localparam int K_RST   = 5;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [AW-1:0] iadr_i;
    logic [1:0]    isiz_i;
    logic          iack_o;
    logic [31:0]   idat_o;
    logic [AW-1:0] madr_o;
    logic          mcyc_o;
    logic          mstb_o;
    logic [15:0]   mdat_i;
    logic          mack_i;
    logic          invalidate_i;
    logic          timeout_o;

    always #5 clk = ~clk;

    ibus_bridge16 #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_i(reset_i), .iadr_i(iadr_i), .isiz_i(isiz_i),
        .iack_o(iack_o), .idat_o(idat_o), .madr_o(madr_o), .mcyc_o(mcyc_o),
        .mstb_o(mstb_o), .mdat_i(mdat_i), .mack_i(mack_i),
        .invalidate_i(invalidate_i), .timeout_o(timeout_o)
    );

    // stimulus per cycle
    bit            s_rst  [MAXC];
    logic [1:0]    s_isiz [MAXC];
    logic [AW-1:0] s_iadr [MAXC];
    bit            s_mack [MAXC];
    logic [15:0]   s_mdat [MAXC];
    bit            s_inv  [MAXC];
    // expected outputs per cycle
    bit            e_mcyc [MAXC];
    bit            e_iack [MAXC];
    bit            e_to   [MAXC];
    logic [AW-1:0] e_madr [MAXC];
    logic [31:0]   e_idat [MAXC];

    logic [AW-1:0] m_madr;
    logic [31:0]   m_idat;
    bit            c_vld;
    logic [AW-1:0] c_tag;
    logic [31:0]   c_dat;
    int            cur;
    int            ncyc;
    bit            sched_ready = 1'b0;
    int            n_chk = 0;
    int            n_pass = 0;

    function automatic logic [1:0] idle_code();
        case ($urandom_range(2))
            0:       return 2'b00;
            1:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic [AW-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic put(input int c, input bit rst, input logic [1:0] isiz, input logic [AW-1:0] a,
                       input bit mack, input logic [15:0] d, input bit inv);
        s_rst[c] = rst; s_isiz[c] = isiz; s_iadr[c] = a;
        s_mack[c] = mack; s_mdat[c] = d; s_inv[c] = inv;
    endtask

    // any=1 allows a request code, used only where the bridge must ignore it
    task automatic put_fill(input int c, input bit any);
        put(c, 1'b0, any ? 2'($urandom_range(3)) : idle_code(), rnd64(),
            1'($urandom_range(1)), 16'($urandom()), 1'b0);
    endtask

    task automatic expect_out(input int c, input bit mcyc, input bit iack, input bit to);
        e_mcyc[c] = mcyc; e_iack[c] = iack; e_to[c] = to;
        e_madr[c] = m_madr; e_idat[c] = m_idat;
    endtask

    task automatic gen_idle(input int n, input bit inv_first);
        for (int i = 0; i < n; i++) begin
            put_fill(cur, 1'b0);
            if (i == 0 && inv_first) begin
                s_inv[cur] = 1'b1;
                if (CACHE_ON) c_vld = 1'b0;
            end
            expect_out(cur, 1'b0, 1'b0, 1'b0);
            cur++;
        end
    endtask

    // One halfword phase: 'waits' cycles without mack, then (if ack) one cycle with mack.
    task automatic mem_half(input logic [AW-1:0] a, input int waits, input bit ack,
                            input logic [15:0] d, input bit wd);
        m_madr = a;
        for (int i = 0; i < waits + (ack ? 1 : 0); i++) begin
            put(cur, 1'b0, wd ? idle_code() : 2'b10, rnd64(), (i == waits),
                (i == waits) ? d : 16'($urandom()), 1'b0);
            expect_out(cur, 1'b1, 1'b0, 1'b0);
            cur++;
        end
    endtask

    task automatic finish_ack(input bit to, input logic [31:0] w, input logic [AW-1:0] base);
        put_fill(cur, 1'b1);
        m_idat = w;
        expect_out(cur, 1'b0, 1'b1, to);
        if (to) begin
            c_vld = 1'b0;
        end else begin
            c_vld = 1'b1; c_tag = base; c_dat = w;
        end
        cur++;
    endtask

    task automatic gen_fetch(input logic [AW-1:0] addr, input int wl, input int wh, input int kind,
                             input logic [31:0] word, input bit inv);
        logic [AW-1:0] base;
        base = {addr[AW-1:2], 2'b00};
        put(cur, 1'b0, 2'b10, addr, 1'($urandom_range(1)), 16'($urandom()), inv);
        expect_out(cur, 1'b0, 1'b0, 1'b0);
        cur++;
        if (CACHE_ON && c_vld && !inv && c_tag == base) begin
            put_fill(cur, 1'b1);
            m_idat = c_dat;
            expect_out(cur, 1'b0, 1'b1, 1'b0);
            cur++;
            return;
        end
        if (CACHE_ON && inv) c_vld = 1'b0;
        case (kind)
            K_RST: begin
                m_madr = base;
                put(cur, 1'b1, 2'b10, addr, 1'b0, 16'($urandom()), 1'b0);
                expect_out(cur, 1'b1, 1'b0, 1'b0);
                cur++;
                m_madr = '0; m_idat = 32'h0; c_vld = 1'b0;
            end
            K_TO_LO: begin
                mem_half(base, TO, 1'b0, 16'h0, 1'b0);
                finish_ack(1'b1, 32'h0, base);
            end
            K_TO_HI: begin
                mem_half(base, wl, 1'b1, word[15:0], 1'b0);
                mem_half(base + 64'd2, TO, 1'b0, 16'h0, 1'b0);
                finish_ack(1'b1, 32'h0, base);
            end
            K_WD_LO: begin
                mem_half(base, wl, 1'b1, word[15:0], 1'b1);
            end
            K_WD_HI: begin
                mem_half(base, wl, 1'b1, word[15:0], 1'b0);
                mem_half(base + 64'd2, wh, 1'b1, word[31:16], 1'b1);
            end
            default: begin
                mem_half(base, wl, 1'b1, word[15:0], 1'b0);
                mem_half(base + 64'd2, wh, 1'b1, word[31:16], 1'b0);
                finish_ack(1'b0, word, base);
            end
        endcase
    endtask

    task automatic build();
        logic [AW-1:0] a;
        int r, kind, n;
        m_madr = '0; m_idat = 32'h0; c_vld = 1'b0; c_tag = '0; c_dat = 32'h0;
        for (int c = 0; c < 2; c++) begin
            put(c, 1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 16'h0, 1'b0);
        end
        expect_out(1, 1'b0, 1'b0, 1'b0);
        cur = 2;
        gen_fetch(64'hFFFF_FFFF_FFFF_FF00, 0, 0, K_NORM, 32'h0000_0013, 1'b0);
        gen_fetch(64'h124, 2, 1, K_NORM, 32'h1240_0113, 1'b0);
        gen_fetch(64'h200, 0, 0, K_TO_LO, 32'h0, 1'b0);
        gen_fetch(64'h126, 0, 0, K_NORM, 32'h1240_0113, 1'b0);
        gen_fetch(64'h300, 0, 1, K_WD_HI, 32'hDEAD_BEEF, 1'b0);
        gen_fetch(64'h400, 0, 0, K_RST, 32'h0, 1'b0);
        gen_fetch(64'h128, 0, 0, K_NORM, 32'hCAFE_0128, 1'b0);
        gen_fetch(64'h128, 0, 0, K_NORM, 32'hCAFE_0128, 1'b0);
        gen_idle(1, 1'b1);
        gen_fetch(64'h128, 1, 0, K_NORM, 32'hCAFE_0128, 1'b0);
        n = 0;
        while (cur < MAXC - 40 && n < 350) begin
            case ($urandom_range(4))
                0:       a = 64'h128 | 64'($urandom_range(3));
                1:       a = 64'hFFFF_FFFF_FFFF_FFFC | 64'($urandom_range(3));
                2:       a = 64'h200 + 64'($urandom_range(7));
                default: a = rnd64();
            endcase
            r = $urandom_range(99);
            kind = (r < 55) ? K_NORM : (r < 63) ? K_TO_LO : (r < 71) ? K_TO_HI :
                   (r < 79) ? K_WD_LO : (r < 87) ? K_WD_HI : (r < 92) ? K_RST : K_NORM;
            gen_fetch(a, $urandom_range(TO - 1), $urandom_range(TO - 1), kind,
                      mem_word({a[AW-1:2], 2'b00}), (r >= 92));
            gen_idle($urandom_range(2), ($urandom_range(9) == 0));
            n++;
        end
        gen_idle(3, 1'b0);
        ncyc = cur;
    endtask

    task automatic drive(input int c);
        reset_i = s_rst[c]; isiz_i = s_isiz[c]; iadr_i = s_iadr[c];
        mack_i = s_mack[c]; mdat_i = s_mdat[c]; invalidate_i = s_inv[c];
    endtask

    task automatic chk(input string nm, input int c, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
    endtask

    initial begin
        build();
        sched_ready = 1'b1;
        drive(0);
        for (int c = 1; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            drive(c);
        end
    end

    initial begin
        wait (sched_ready);
        for (int c = 1; c < ncyc; c++) begin
            @(negedge clk);
            chk("mcyc", c, 64'(mcyc_o), 64'(e_mcyc[c]));
            chk("mstb", c, 64'(mstb_o), 64'(e_mcyc[c]));
            chk("madr", c, madr_o, e_madr[c]);
            chk("iack", c, 64'(iack_o), 64'(e_iack[c]));
            chk("timeout", c, 64'(timeout_o), 64'(e_to[c]));
            chk("idat", c, 64'(idat_o), 64'(e_idat[c]));
            case (c)
                1, 2: begin
                    chk("lit_rst_mcyc", c, 64'(mcyc_o), 64'd0);
                    chk("lit_rst_iack", c, 64'(iack_o), 64'd0);
                end
                3:  chk("lit_lo_adr", c, madr_o, 64'hFFFF_FFFF_FFFF_FF00);
                4:  chk("lit_hi_adr", c, madr_o, 64'hFFFF_FFFF_FFFF_FF02);
                5: begin
                    chk("lit_ack0", c, 64'(iack_o), 64'd1);
                    chk("lit_word0", c, 64'(idat_o), 64'h0000_0013);
                end
                12: begin
                    chk("lit_ack_wait", c, 64'(iack_o), 64'd1);
                    chk("lit_word_wait", c, 64'(idat_o), 64'h1240_0113);
                end
                18: begin
                    chk("lit_to_pulse", c, 64'(timeout_o), 64'd1);
                    chk("lit_to_ack", c, 64'(iack_o), 64'd1);
                    chk("lit_to_data", c, 64'(idat_o), 64'd0);
                    chk("lit_to_mcyc", c, 64'(mcyc_o), 64'd0);
                end
                20: chk("lit_align_adr", c, madr_o, 64'h124);
                22: chk("lit_align_word", c, 64'(idat_o), 64'h1240_0113);
                26: chk("lit_wd_hi_busy", c, 64'(mcyc_o), 64'd1);
                27: begin
                    chk("lit_wd_noack", c, 64'(iack_o), 64'd0);
                    chk("lit_wd_hold", c, 64'(idat_o), 64'h1240_0113);
                end
                29: begin
                    chk("lit_midrst_mcyc", c, 64'(mcyc_o), 64'd0);
                    chk("lit_midrst_adr", c, madr_o, 64'd0);
                end
`ifdef FETCH_CACHE_EN
                34: begin
                    chk("lit_hit_ack", c, 64'(iack_o), 64'd1);
                    chk("lit_hit_nomem", c, 64'(mstb_o), 64'd0);
                    chk("lit_hit_word", c, 64'(idat_o), 64'hCAFE_0128);
                end
`endif
                default: ;
            endcase
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
